// File: rtl/lattice_scan_counter.sv
// Two-dimensional lattice sweep generator: walks every node of a GRID_W x GRID_H
// lattice in forward or reverse raster order behind a valid/ready handshake.
module lattice_scan_counter #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int COL_W  = $clog2(GRID_W),
  parameter int ROW_W  = $clog2(GRID_H),
  parameter int IDX_W  = $clog2(GRID_W * GRID_H)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Reverse,
  input  logic             Abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic [IDX_W-1:0] idx,
  output logic             edge_l,
  output logic             edge_r,
  output logic             edge_t,
  output logic             edge_b,
  output logic             busy,
  output logic             done
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(GRID_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(GRID_H - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(GRID_W * GRID_H - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_rev;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [IDX_W-1:0] r_idx;
  logic             r_edge_l;
  logic             r_edge_r;
  logic             r_edge_t;
  logic             r_edge_b;

  logic             w_beat;
  logic             w_last;
  logic [COL_W-1:0] w_col_nxt;
  logic [ROW_W-1:0] w_row_nxt;
  logic [IDX_W-1:0] w_idx_nxt;

  // Next coordinate: idx runs as its own counter so it never needs a multiplier.
  always_comb begin
    w_beat    = (r_state == SCAN) && r_valid && out_ready;
    w_last    = r_rev ? ((r_col == '0) && (r_row == '0))
                      : ((r_col == COL_MAX) && (r_row == ROW_MAX));
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    w_idx_nxt = r_idx;
    if (Abort) begin
      w_col_nxt = '0;
      w_row_nxt = '0;
      w_idx_nxt = '0;
    end else if ((r_state == IDLE) && Start) begin
      if (Reverse) begin
        w_col_nxt = COL_MAX;
        w_row_nxt = ROW_MAX;
        w_idx_nxt = IDX_MAX;
      end else begin
        w_col_nxt = '0;
        w_row_nxt = '0;
        w_idx_nxt = '0;
      end
    end else if (w_beat && !w_last) begin
      if (r_rev) begin
        w_idx_nxt = r_idx - IDX_W'(1);
        if (r_col == '0) begin
          w_col_nxt = COL_MAX;
          w_row_nxt = r_row - ROW_W'(1);
        end else begin
          w_col_nxt = r_col - COL_W'(1);
        end
      end else begin
        w_idx_nxt = r_idx + IDX_W'(1);
        if (r_col == COL_MAX) begin
          w_col_nxt = '0;
          w_row_nxt = r_row + ROW_W'(1);
        end else begin
          w_col_nxt = r_col + COL_W'(1);
        end
      end
    end
  end

  // Registered control FSM, coordinates and boundary flags.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state  <= IDLE;
      r_rev    <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_col    <= '0;
      r_row    <= '0;
      r_idx    <= '0;
      r_edge_l <= 1'b1;
      r_edge_r <= 1'b0;
      r_edge_t <= 1'b1;
      r_edge_b <= 1'b0;
    end else begin
      r_col    <= w_col_nxt;
      r_row    <= w_row_nxt;
      r_idx    <= w_idx_nxt;
      r_edge_l <= (w_col_nxt == '0);
      r_edge_r <= (w_col_nxt == COL_MAX);
      r_edge_t <= (w_row_nxt == '0);
      r_edge_b <= (w_row_nxt == ROW_MAX);
      if (Abort) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_done <= 1'b0;
            if (Start) begin
              r_state <= SCAN;
              r_rev   <= Reverse;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          SCAN: begin
            if (w_beat && w_last) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_valid = r_valid;
  assign col       = r_col;
  assign row       = r_row;
  assign idx       = r_idx;
  assign edge_l    = r_edge_l;
  assign edge_r    = r_edge_r;
  assign edge_t    = r_edge_t;
  assign edge_b    = r_edge_b;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
